// File: rtl/bram_port_responder.sv
// Memory-side model of a 32-bit BRAM port: byte-enable writes, fixed-latency reads
// with a valid strobe, saturating access counters and sticky address/alignment flags.
module bram_port_responder #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bram_en,
  input  logic [3:0]  bram_we,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_din,
  input  logic        bram_rst,
  output logic [31:0] bram_dout,
  output logic        rd_valid,
  input  logic        clr_stats,
  output logic [31:0] wr_cnt,
  output logic [31:0] rd_cnt,
  output logic        addr_err,
  output logic        align_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Port protocol: an access is any edge with bram_en=1 (write if bram_we!=0, else read);
  // there is no back-pressure. Each read yields exactly one rd_valid pulse READ_LATENCY
  // edges later, with bram_dout valid only while rd_valid is high.
  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  wr_acc;
  logic                  rd_acc;

  assign off      = bram_addr - BASE_ADDR;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign in_range = (off[31:DEPTH_LOG2+2] == '0);
  assign wr_acc   = bram_en && (bram_we != 4'b0000);
  assign rd_acc   = bram_en && (bram_we == 4'b0000);

  // Storage is never reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[idx][8*b +: 8] <= bram_din[8*b +: 8];
      end
    end
  end

  // Read pipeline: stage-valid bits form a shift register; data only moves with a
  // valid read, so writes and idle cycles leave bram_dout untouched (NO_CHANGE).
  logic [31:0]             s_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] s_valid;

  always_ff @(posedge clk) begin
    if (rst || bram_rst) begin
      s_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) s_data[i] <= '0;
    end else begin
      s_valid[0] <= rd_acc;
      if (rd_acc) s_data[0] <= in_range ? mem[idx] : 32'h0000_0000;
      for (int i = 1; i < READ_LATENCY; i++) begin
        s_valid[i] <= s_valid[i-1];
        if (s_valid[i-1]) s_data[i] <= s_data[i-1];
      end
    end
  end

  assign bram_dout = s_data[READ_LATENCY-1];
  assign rd_valid  = s_valid[READ_LATENCY-1];

  // Statistics: clr_stats wins over a same-cycle access; reads killed by bram_rst
  // are not counted.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      addr_err  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (wr_acc && (wr_cnt != 32'hFFFF_FFFF)) wr_cnt <= wr_cnt + 32'd1;
      if (rd_acc && !bram_rst && (rd_cnt != 32'hFFFF_FFFF)) rd_cnt <= rd_cnt + 32'd1;
      if (bram_en && !in_range) addr_err <= 1'b1;
      if (bram_en && (bram_addr[1:0] != 2'b00)) align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_port_responder.sv
// Directed bench for bram_port_responder: one latency-1 and one latency-2 instance
// share the same port stimulus; outputs are checked against hand-computed values.
module tb_bram_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic        bram_rst;
  logic        clr_stats;

  logic [31:0] dout1, wr_cnt1, rd_cnt1;
  logic        vld1, aerr1, lerr1;
  logic [31:0] dout2, wr_cnt2, rd_cnt2;
  logic        vld2, aerr2, lerr2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_port_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_rst(bram_rst), .bram_dout(dout1), .rd_valid(vld1),
    .clr_stats(clr_stats), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1), .addr_err(aerr1),
    .align_err(lerr1)
  );

  bram_port_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_rst(bram_rst), .bram_dout(dout2), .rd_valid(vld2),
    .clr_stats(clr_stats), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2), .addr_err(aerr2),
    .align_err(lerr2)
  );

  // Advance to 1 ns after the next rising edge; inputs are driven and outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] din);
    bram_en   = en;
    bram_we   = we;
    bram_addr = addr;
    bram_din  = din;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_l1(input string tag, input logic v, input logic [31:0] d);
    chk({tag, "_l1_valid"}, {31'd0, vld1}, {31'd0, v});
    if (v) chk({tag, "_l1_dout"}, dout1, d);
  endtask

  task automatic chk_l2(input string tag, input logic v, input logic [31:0] d);
    chk({tag, "_l2_valid"}, {31'd0, vld2}, {31'd0, v});
    chk({tag, "_l2_dout"}, dout2, d);
  endtask

  initial begin
    rst = 1'b1; bram_rst = 1'b0; clr_stats = 1'b0;
    // Reset with a write held on the port: it must be ignored.
    drive(1'b1, 4'hF, 32'h14, 32'hDEAD_BEEF);
    repeat (3) tick();
    chk("rst_dout1", dout1, 32'h0);
    chk("rst_valid1", {31'd0, vld1}, 32'd0);
    chk("rst_wr_cnt1", wr_cnt1, 32'd0);
    chk("rst_rd_cnt1", rd_cnt1, 32'd0);
    chk("rst_flags1", {30'd0, aerr1, lerr1}, 32'd0);
    chk("rst_dout2", dout2, 32'h0);
    chk("rst_valid2", {31'd0, vld2}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 4'h0, 32'h14, 32'h0);
    tick();
    idle();
    chk("rst_rd_valid", {31'd0, vld1}, 32'd1);
    n_vec++;
    assert (dout1 !== 32'hDEAD_BEEF) else begin
      n_err++;
      $error("FAIL rst_write_dropped: observed %h expected not %h", dout1, 32'hDEAD_BEEF);
    end
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;

    // Initiator pattern: four writes, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF, 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 32'(4 * i), 32'h0);
      tick();
      chk_l1("b2b", 1'b1, 32'h100 + 32'(i));
      if (i == 0) chk({"b2b_first_l2_valid"}, {31'd0, vld2}, 32'd0);
      else chk_l2("b2b", 1'b1, 32'h100 + 32'(i - 1));
    end
    idle();
    tick();
    chk("b2b_tail_l1_valid", {31'd0, vld1}, 32'd0);
    chk_l2("b2b_tail", 1'b1, 32'h103);
    tick();
    chk("b2b_done_l2_valid", {31'd0, vld2}, 32'd0);
    chk("b2b_wr_cnt", wr_cnt1, 32'd4);
    chk("b2b_rd_cnt", rd_cnt1, 32'd4);
    chk("b2b_rd_cnt_l2", rd_cnt2, 32'd4);

    // Byte enables; writes must not disturb bram_dout.
    drive(1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF); tick();
    drive(1'b1, 4'b0101, 32'h10, 32'h1234_5678); tick();
    chk("nochange_dout", dout1, 32'h103);
    chk("nochange_valid", {31'd0, vld1}, 32'd0);
    drive(1'b1, 4'h0, 32'h10, 32'h0); tick(); idle();
    chk_l1("byte_en", 1'b1, 32'hFF34_FF78);

    // Errors: out of range, unaligned, dropped out-of-range write.
    drive(1'b1, 4'h0, 32'h40, 32'h0); tick(); idle();
    chk_l1("oor_read", 1'b1, 32'h0);
    chk("oor_addr_err", {31'd0, aerr1}, 32'd1);
    chk("oor_align_err", {31'd0, lerr1}, 32'd0);
    drive(1'b1, 4'h0, 32'h2, 32'h0); tick(); idle();
    chk_l1("unaligned", 1'b1, 32'h100);
    chk("unaligned_align_err", {31'd0, lerr1}, 32'd1);
    drive(1'b1, 4'hF, 32'h44, 32'hAAAA_AAAA); tick();
    drive(1'b1, 4'h0, 32'h4, 32'h0); tick(); idle();
    chk_l1("oor_write_dropped", 1'b1, 32'h101);
    chk("err_wr_cnt", wr_cnt1, 32'd7);
    chk("err_rd_cnt", rd_cnt1, 32'd8);
    // clr_stats with a same-cycle write: write lands, nothing counted.
    clr_stats = 1'b1;
    drive(1'b1, 4'hF, 32'h8, 32'h55); tick();
    clr_stats = 1'b0; idle();
    chk("clr_wr_cnt", wr_cnt1, 32'd0);
    chk("clr_rd_cnt", rd_cnt1, 32'd0);
    chk("clr_flags", {30'd0, aerr1, lerr1}, 32'd0);
    drive(1'b1, 4'h0, 32'h8, 32'h0); tick(); idle();
    chk_l1("clr_write_landed", 1'b1, 32'h55);
    chk("clr_then_rd_cnt", rd_cnt1, 32'd1);

    // bram_rst on the second of three consecutive reads.
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    drive(1'b1, 4'h0, 32'h0, 32'h0); tick();
    chk_l1("brst_a", 1'b1, 32'h100);
    chk("brst_a_l2_valid", {31'd0, vld2}, 32'd0);
    bram_rst = 1'b1; drive(1'b1, 4'h0, 32'h4, 32'h0); tick(); bram_rst = 1'b0;
    chk("brst_b_l1_valid", {31'd0, vld1}, 32'd0);
    chk("brst_b_l1_dout", dout1, 32'h0);
    chk_l2("brst_b", 1'b0, 32'h0);
    drive(1'b1, 4'h0, 32'h8, 32'h0); tick(); idle();
    chk_l1("brst_c", 1'b1, 32'h55);
    chk_l2("brst_c", 1'b0, 32'h0);
    tick();
    chk_l2("brst_d", 1'b1, 32'h55);
    tick();
    chk("brst_e_l2_valid", {31'd0, vld2}, 32'd0);
    chk("brst_rd_cnt_l2", rd_cnt2, 32'd2);
    chk("brst_rd_cnt_l1", rd_cnt1, 32'd2);

    // Saturation of the write counter.
    force u_l1.wr_cnt = 32'hFFFF_FFFE;
    #1 release u_l1.wr_cnt;
    chk("sat_preload", wr_cnt1, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 32'h30, 32'(i)); tick();
      chk("sat_wr_cnt", wr_cnt1, 32'hFFFF_FFFF);
    end
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_responder.md
# bram_port_responder

Synthesizable BRAM-port responder: the memory side of the 32-bit en/we/addr/din/dout port that the PL RAM-control initiator drives. It sits in place of a BRAM on that port in PL-only builds and benches. It stores words with byte-enable writes, returns read data after a fixed latency with a valid strobe, and keeps access counters plus sticky error flags for software or testbench checking.

## Interface
- DEPTH_LOG2, 10: number of 32-bit words is 2**DEPTH_LOG2.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.
- READ_LATENCY, 1: read latency in cycles; legal values are 1 and 2 only.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- bram_en  in  1  access enable.
- bram_we  in  4  byte write enables; bit i covers bits [8i+7:8i].
- bram_addr  in  32  byte address.
- bram_din  in  32  write data from the initiator.
- bram_rst  in  1  port output-register reset from the initiator; synchronous, active-high.
- bram_dout  out  32  read data.
- rd_valid  out  1  one-cycle strobe; bram_dout is valid while it is high.
- clr_stats  in  1  clears the counters and the sticky flags.
- wr_cnt  out  32  number of write accesses; saturates at 32'hFFFF_FFFF.
- rd_cnt  out  32  number of read accesses; saturates.
- addr_err  out  1  sticky: an access fell out of range.
- align_err  out  1  sticky: an access had bram_addr[1:0] != 0.

## Operation
- An access happens on any clk edge with bram_en=1.
  - It is a write if bram_we != 0.
  - It is a read if bram_we == 0.
- Offset: off = bram_addr - BASE_ADDR, 32-bit modular arithmetic. Word index = off[DEPTH_LOG2+1:2].
- In range means off[31:DEPTH_LOG2+2] == 0. A BASE_ADDR underflow wraps to a large off, so it counts as out of range.
- Write:
  - Only the enabled bytes of the indexed word are updated.
  - bram_dout holds its value; no rd_valid is generated.
  - wr_cnt increments.
- Read:
  - The indexed word enters the read pipeline; rd_cnt increments.
  - Mode is NO_CHANGE: a write never alters the output pipeline.
- Out-of-range access:
  - A write is dropped; memory is unchanged.
  - A read returns 32'h0000_0000 with rd_valid asserted.
  - addr_err is set. Counters still increment.
- Unaligned access: bram_addr[1:0] is ignored for indexing; align_err is set; the access otherwise proceeds normally.
- bram_rst=1:
  - Zeroes every output/pipeline data register and kills in-flight rd_valid strobes.
  - A read sampled in the same cycle produces no rd_valid and is not counted.
  - Writes in that cycle still occur and are counted.
- clr_stats=1:
  - Zeroes wr_cnt, rd_cnt, addr_err and align_err.
  - Takes priority over an access in the same cycle: that access is performed but neither counted nor flagged.
- rst=1:
  - bram_dout=0, rd_valid=0, wr_cnt=0, rd_cnt=0, addr_err=0, align_err=0, pipeline flushed.
  - Memory contents are not cleared; they are undefined until written.
  - Accesses during rst are ignored, including writes.
- There is no state machine beyond the read pipeline: the stage-valid bits form a shift register of length READ_LATENCY.

## Timing
- Read sampled at edge N:
  - bram_dout and rd_valid update at edge N+READ_LATENCY.
  - rd_valid is high for exactly one cycle per read.
- Back-to-back reads every cycle give one rd_valid per cycle, in order, with no bubbles.
- Write at edge N is visible to a read sampled at edge N+1.
- A read and a write to the same word cannot occur in the same cycle (single port).
- Counters and sticky flags update at the edge that samples the access; they are visible the following cycle.
- READ_LATENCY=2: the second register stage also holds zero after bram_rst or rst.

## Test plan
- Reset check: assert rst for 3 cycles with bram_en=1, bram_we=4'hF -> all outputs 0; a subsequent read of that address does not return the write data.
- Initiator pattern: write 4 words at 0x0/0x4/0x8/0xC with data 0x100..0x103, then read them back-to-back -> rd_valid on 4 consecutive cycles starting READ_LATENCY cycles after the first read, data 0x100..0x103, wr_cnt=4, rd_cnt=4.
- Byte enables: write 0xFFFF_FFFF to 0x10, then 0x1234_5678 with we=4'b0101 -> readback 0xFF34_FF78.
- Errors: read at BASE_ADDR + 4*2**DEPTH_LOG2 -> bram_dout=0 with rd_valid, addr_err=1. Read at 0x2 -> word 0 returned, align_err=1. clr_stats -> both flags and both counters are 0.
- bram_rst mid-stream (READ_LATENCY=2): issue reads on 3 consecutive cycles, pulse bram_rst on the second -> only the third read produces rd_valid; bram_dout is 0 in between; rd_cnt=2.
- Saturation: force wr_cnt to 32'hFFFF_FFFE, do 3 writes -> wr_cnt=32'hFFFF_FFFF.
